// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared state encoding and default sizes for the memory bridge
package mem_bridge_pkg;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True while an access is in flight on the bus and the core must stay held.
  function automatic logic state_busy(input state_t s);
    return (s == ST_REQ) || (s == ST_RESP);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - clearable saturating counter with expire flag
module mem_timeout_cnt #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] LAST_V = W'(MAX - 1);

  logic [W-1:0] count;

  // Count enabled cycles since the last clear, sticking at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

  // Expire in the enabled cycle whose increment brings the count to MAX,
  // so exactly MAX enabled cycles elapse before the owner acts on it.
  assign expire = en && (count == LAST_V);

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - core load/store port to valid/ready memory bus bridge
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [ADDR_W-1:0] addr_mem_rd_i,
  input  logic [ADDR_W-1:0] addr_mem_wr_i,
  input  logic [DATA_W-1:0] data_mem_wr_i,
  output logic [DATA_W-1:0] data_mem_o,
  output logic              stall_load_o,
  output logic              stall_store_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              rsp_valid_i,
  output logic              rsp_ready_o,
  input  logic [DATA_W-1:0] rsp_rdata_i,
  input  logic              rsp_err_i,
  output logic              err_o
);

  state_t            state;
  logic              op_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_expire;

  // The wait counter restarts on the request handshake that enters RESP.
  assign tmo_clr = (state == ST_REQ) && req_ready_i;
  assign tmo_en  = (state == ST_RESP);

  mem_timeout_cnt #(
    .MAX(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Bridge FSM: latch the core request, drive the bus handshakes, collect the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_we       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_valid_o <= 1'b0;
      rsp_ready_o <= 1'b0;
      err_o       <= 1'b0;
      data_mem_o  <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_wr_en_i) begin
            op_we       <= 1'b1;
            addr_q      <= addr_mem_wr_i;
            wdata_q     <= data_mem_wr_i;
            req_valid_o <= 1'b1;
            state       <= ST_REQ;
          end else if (mem_rd_en_i) begin
            op_we       <= 1'b0;
            addr_q      <= addr_mem_rd_i;
            wdata_q     <= '0;
            req_valid_o <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_ready_i) begin
            req_valid_o <= 1'b0;
            rsp_ready_o <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_valid_i) begin
            rsp_ready_o <= 1'b0;
            state       <= ST_DONE;
            if (rsp_err_i) begin
              err_o <= 1'b1;
              if (!op_we) begin
                data_mem_o <= '0;
              end
            end else if (!op_we) begin
              data_mem_o <= rsp_rdata_i;
            end
          end else if (tmo_expire) begin
            rsp_ready_o <= 1'b0;
            err_o       <= 1'b1;
            state       <= ST_DONE;
            if (!op_we) begin
              data_mem_o <= '0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus payload comes straight from the latched request so it stays stable in REQ.
  assign req_we_o    = op_we;
  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;

  // Stall follows the core request in IDLE (store wins) and the latched op while busy.
  assign stall_store_o = ((state == ST_IDLE) && mem_wr_en_i) ||
                         (state_busy(state) && op_we);
  assign stall_load_o  = ((state == ST_IDLE) && mem_rd_en_i && !mem_wr_en_i) ||
                         (state_busy(state) && !op_we);

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed self-checking bench for mem_bridge
module tb_mem_bridge;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              mem_rd_en_i;
  logic              mem_wr_en_i;
  logic [ADDR_W-1:0] addr_mem_rd_i;
  logic [ADDR_W-1:0] addr_mem_wr_i;
  logic [DATA_W-1:0] data_mem_wr_i;
  logic [DATA_W-1:0] data_mem_o;
  logic              stall_load_o;
  logic              stall_store_o;
  logic              req_valid_o;
  logic              req_ready_i;
  logic              req_we_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic [DATA_W-1:0] req_wdata_o;
  logic              rsp_valid_i;
  logic              rsp_ready_o;
  logic [DATA_W-1:0] rsp_rdata_i;
  logic              rsp_err_i;
  logic              err_o;

  int checks;
  int errors;
  int n;

  mem_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd_en_i   (mem_rd_en_i),
    .mem_wr_en_i   (mem_wr_en_i),
    .addr_mem_rd_i (addr_mem_rd_i),
    .addr_mem_wr_i (addr_mem_wr_i),
    .data_mem_wr_i (data_mem_wr_i),
    .data_mem_o    (data_mem_o),
    .stall_load_o  (stall_load_o),
    .stall_store_o (stall_store_o),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_we_o      (req_we_o),
    .req_addr_o    (req_addr_o),
    .req_wdata_o   (req_wdata_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_rdata_i   (rsp_rdata_i),
    .rsp_err_i     (rsp_err_i),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive cycles (sampled on negedge) with the chosen stall high.
  task automatic count_stall(input bit store, output int cnt);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((store ? stall_store_o : stall_load_o) === 1'b1) cnt++;
      else break;
    end
  endtask

  // Load with an always-ready bus and a response already waiting.
  task automatic load_fast(input logic [63:0] a, input logic [63:0] rd, input logic e,
                           output int cnt);
    mem_rd_en_i   = 1'b1;
    addr_mem_rd_i = a;
    req_ready_i   = 1'b1;
    rsp_valid_i   = 1'b1;
    rsp_rdata_i   = rd;
    rsp_err_i     = e;
    count_stall(1'b0, cnt);
  endtask

  task automatic release_all();
    tick();
    mem_rd_en_i = 1'b0;
    mem_wr_en_i = 1'b0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_err_i   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mem_rd_en_i = 1'b0;
    mem_wr_en_i = 1'b0;
    addr_mem_rd_i = '0;
    addr_mem_wr_i = '0;
    data_mem_wr_i = '0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = '0;
    rsp_err_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_data", data_mem_o, 64'd0);
    check("rst_stall_idle", 64'(stall_load_o), 64'd0);
    mem_rd_en_i = 1'b1;
    #1;
    check("rst_stall_follows_en", 64'(stall_load_o), 64'd1);
    mem_rd_en_i = 1'b0;
    tick();
    rst = 1'b0;

    // Minimum-latency load
    tick();
    load_fast(64'h80, 64'hDEADBEEF, 1'b0, n);
    check("load_stall_cycles", 64'(n), 64'd3);
    check("load_data", data_mem_o, 64'hDEADBEEF);
    check("load_err", 64'(err_o), 64'd0);
    release_all();

    // Store with bus back-pressure
    mem_wr_en_i   = 1'b1;
    addr_mem_wr_i = 64'h100;
    data_mem_wr_i = 64'h55;
    @(negedge clk);
    check("st_idle_stall", 64'(stall_store_o), 64'd1);
    check("st_idle_req_valid", 64'(req_valid_o), 64'd0);
    tick();
    addr_mem_wr_i = 64'hFFF;
    data_mem_wr_i = 64'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_wait_valid", 64'(req_valid_o), 64'd1);
      check("st_wait_addr", req_addr_o, 64'h100);
      check("st_wait_wdata", req_wdata_o, 64'h55);
      check("st_wait_we", 64'(req_we_o), 64'd1);
      check("st_wait_stall", 64'(stall_store_o), 64'd1);
      if (i < 3) tick();
    end
    tick();
    req_ready_i = 1'b1;
    @(negedge clk);
    check("st_hs_valid", 64'(req_valid_o), 64'd1);
    tick();
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'h1234;
    @(negedge clk);
    check("st_resp_ready", 64'(rsp_ready_o), 64'd1);
    check("st_resp_req_valid", 64'(req_valid_o), 64'd0);
    check("st_resp_stall", 64'(stall_store_o), 64'd1);
    tick();
    @(negedge clk);
    check("st_done_stall", 64'(stall_store_o), 64'd0);
    check("st_done_rsp_ready", 64'(rsp_ready_o), 64'd0);
    check("st_data_unchanged", data_mem_o, 64'hDEADBEEF);
    release_all();

    // Simultaneous load and store: store wins
    mem_rd_en_i   = 1'b1;
    addr_mem_rd_i = 64'h200;
    mem_wr_en_i   = 1'b1;
    addr_mem_wr_i = 64'h300;
    data_mem_wr_i = 64'h77;
    @(negedge clk);
    check("both_stall_store", 64'(stall_store_o), 64'd1);
    check("both_stall_load", 64'(stall_load_o), 64'd0);
    tick();
    @(negedge clk);
    check("both_we", 64'(req_we_o), 64'd1);
    check("both_addr", req_addr_o, 64'h300);
    tick();
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'h9999;
    count_stall(1'b1, n);
    check("both_stall_cycles", 64'(n), 64'd2);
    check("both_data_unchanged", data_mem_o, 64'hDEADBEEF);
    release_all();

    // Error response on a load
    load_fast(64'h88, 64'h5A5A, 1'b1, n);
    check("err_stall_cycles", 64'(n), 64'd3);
    check("err_pulse", 64'(err_o), 64'd1);
    check("err_data_zero", data_mem_o, 64'd0);
    release_all();
    @(negedge clk);
    check("err_pulse_end", 64'(err_o), 64'd0);

    // Reload nonzero data, then time out
    load_fast(64'h90, 64'hCAFEF00D, 1'b0, n);
    check("load2_data", data_mem_o, 64'hCAFEF00D);
    release_all();
    mem_rd_en_i   = 1'b1;
    addr_mem_rd_i = 64'h40;
    req_ready_i   = 1'b1;
    count_stall(1'b0, n);
    check("tmo_stall_cycles", 64'(n), 64'd257);
    check("tmo_err", 64'(err_o), 64'd1);
    check("tmo_data_zero", data_mem_o, 64'd0);
    check("tmo_rsp_ready", 64'(rsp_ready_o), 64'd0);
    release_all();
    @(negedge clk);
    check("tmo_err_end", 64'(err_o), 64'd0);

    // Reset during RESP drops the late response
    load_fast(64'h98, 64'h1111, 1'b0, n);
    check("load3_data", data_mem_o, 64'h1111);
    release_all();
    mem_rd_en_i   = 1'b1;
    addr_mem_rd_i = 64'h80;
    req_ready_i   = 1'b1;
    @(negedge clk);
    tick();
    tick();
    @(negedge clk);
    check("rr_in_resp", 64'(rsp_ready_o), 64'd1);
    tick();
    rst = 1'b1;
    mem_rd_en_i = 1'b0;
    req_ready_i = 1'b0;
    #1;
    check("rr_rsp_ready", 64'(rsp_ready_o), 64'd0);
    check("rr_req_valid", 64'(req_valid_o), 64'd0);
    check("rr_data", data_mem_o, 64'd0);
    check("rr_stall", 64'(stall_load_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 64'hBAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_late_data", data_mem_o, 64'd0);
      check("rr_late_rsp_ready", 64'(rsp_ready_o), 64'd0);
      check("rr_late_err", 64'(err_o), 64'd0);
      check("rr_late_stall", 64'(stall_load_o), 64'd0);
      check("rr_late_req_valid", 64'(req_valid_o), 64'd0);
      tick();
    end
    rsp_valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter: ADDR_W, default 64, memory address width.
REQ-002 Parameter: DATA_W, default 64, memory data width.
REQ-003 Parameter: TIMEOUT, default 255, maximum cycles spent waiting in RESP.
REQ-004 Port: clk  in  1  single clock; all flops on its rising edge.
REQ-005 Port: rst  in  1  reset; asynchronous, active-high.
REQ-006 Port: mem_rd_en_i  in  1  core load request, held by the core until released.
REQ-007 Port: mem_wr_en_i  in  1  core store request, held by the core until released.
REQ-008 Port: addr_mem_rd_i  in  ADDR_W  load address.
REQ-009 Port: addr_mem_wr_i  in  ADDR_W  store address.
REQ-010 Port: data_mem_wr_i  in  DATA_W  store data.
REQ-011 Port: data_mem_o  out  DATA_W  returned load data to core.
REQ-012 Port: stall_load_o  out  1  holds the core pipeline during a load.
REQ-013 Port: stall_store_o  out  1  holds the core pipeline during a store.
REQ-014 Port: req_valid_o / req_ready_i  out/in  1/1  bus request handshake.
REQ-015 Port: req_we_o  out  1  1 = write, 0 = read.
REQ-016 Port: req_addr_o / req_wdata_o  out  ADDR_W/DATA_W  bus request payload.
REQ-017 Port: rsp_valid_i / rsp_ready_o  in/out  1/1  bus response handshake.
REQ-018 Port: rsp_rdata_i / rsp_err_i  in  DATA_W/1  response data and error flag.
REQ-019 Port: err_o  out  1  one-cycle pulse on bus error or timeout.

Function
REQ-020 FSM states: IDLE, REQ, RESP, DONE; each state lasts at least one cycle.
REQ-021 IDLE: on (rd_en | wr_en), latch op/addr/wdata and go to REQ; wr_en wins if both are asserted.
REQ-022 stall_*_o combinational: asserted in IDLE with matching en in the same cycle, and in REQ/RESP for the latched op; 0 in DONE.
REQ-023 REQ: req_valid_o = 1; payload held stable until req_ready_i; on the handshake go to RESP.
REQ-024 RESP: rsp_ready_o = 1; on rsp_valid_i go to DONE, capturing rsp_rdata_i into data_mem_o for reads only.
REQ-025 rsp_err_i = 1 or timeout: go to DONE, data_mem_o <= 0 for reads, err_o pulses one cycle.
REQ-026 Timeout counter: cleared on entry to RESP; expires when count reaches TIMEOUT with no rsp_valid_i.
REQ-027 DONE: stall released for exactly one cycle so the core advances, then unconditional return to IDLE.
REQ-028 Minimum latency (ready and response immediate): stall high 3 cycles, low on the 4th.
REQ-029 data_mem_o is registered and holds its last value until the next read completes; writes never change it.
REQ-030 req_valid_o and rsp_ready_o are 0 in IDLE and DONE; rsp_valid_i outside RESP is ignored.

Reset
REQ-031 Reset forces IDLE, req_valid_o = 0, rsp_ready_o = 0, err_o = 0, data_mem_o = 0, and the counter to 0.
REQ-032 Reset mid-REQ/RESP aborts the access immediately; no retry is made, and a late response is dropped.
REQ-033 Stall outputs follow REQ-022 from IDLE during and after reset.

Structure
REQ-034 The FSM state encoding, ADDR_W/DATA_W defaults and the TIMEOUT default belong in the shared core package.
REQ-035 One sub-module: mem_timeout_cnt, a clearable, saturating counter with an expire flag.

Verification
REQ-036 Load 0x80, ready=1, response next cycle with rdata 0xDEADBEEF -> stall_load 3 cycles, data_mem_o = 0xDEADBEEF on the 4th.
REQ-037 Store 0x100 data 0x55, req_ready low 4 cycles -> req_valid, addr and wdata stable throughout; stall_store released one cycle after the response.
REQ-038 rd_en and wr_en asserted together -> req_we_o = 1 and stall_store_o = 1.
REQ-039 No response for 255 RESP cycles -> err_o pulse, data_mem_o = 0, stall released.
REQ-040 rst asserted during RESP, rsp_valid arrives 2 cycles later -> IDLE, response ignored, data_mem_o = 0.
